// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-request / pipeline-control bundle between the pipeline stages and pipe_hazard_ctrl.
// int_req_i/int_ack_o handshake: int_req_i is a level held by the requester; int_ack_o pulses once when taken.
interface pipe_hazard_ctrl_if;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_we_i;
    logic        id_is_div_i;
    logic        div_start_i;
    logic [4:0]  div_waddr_i;
    logic        div_ready_i;
    logic        bus_hold_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        int_ack_o;
    logic [2:0]  hold_flag_o;
    logic [2:0]  flush_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        div_pending_o;
    logic        stall_timeout_o;
    logic [1:0]  int_state_o;

    modport slave (
        input  jump_flag_i, jump_addr_i, load_use_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_we_i, id_is_div_i, div_start_i, div_waddr_i, div_ready_i,
               bus_hold_i, int_req_i, int_addr_i,
        output int_ack_o, hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
               div_pending_o, stall_timeout_o, int_state_o
    );

    modport master (
        output jump_flag_i, jump_addr_i, load_use_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_we_i, id_is_div_i, div_start_i, div_waddr_i, div_ready_i,
               bus_hold_i, int_req_i, int_addr_i,
        input  int_ack_o, hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
               div_pending_o, stall_timeout_o, int_state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hold/flush scheduler: merges hazard requests, tracks the outstanding divide,
// drains the pipeline for interrupts and watches for stuck bus stalls.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_WAIT  = 2'd1,
        I_FLUSH = 2'd2
    } int_state_e;

    localparam logic [15:0] WD_LIMIT = 16'(STALL_TIMEOUT);

    int_state_e  state_q, state_d;
    logic        div_pend_q, div_pend_d;
    logic [4:0]  div_rd_q, div_rd_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    logic        div_pend_eff;
    logic        div_rd_match;
    logic        div_hold;
    logic [2:0]  hold_c;
    logic [2:0]  flush_c;
    logic        jump_c;
    logic [31:0] jump_addr_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= I_IDLE;
            div_pend_q <= 1'b0;
            div_rd_q   <= 5'd0;
            wd_cnt_q   <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_pend_q <= div_pend_d;
            div_rd_q   <= div_rd_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // A new issue wins over a same-cycle completion; flushes never touch the scoreboard.
    always_comb begin
        div_pend_d = div_pend_q;
        div_rd_d   = div_rd_q;
        if (hz.div_start_i) begin
            div_pend_d = 1'b1;
            div_rd_d   = hz.div_waddr_i;
        end else if (hz.div_ready_i) begin
            div_pend_d = 1'b0;
        end
    end

    always_comb begin
        wd_cnt_d = 16'd0;
        if (hz.bus_hold_i) begin
            wd_cnt_d = (wd_cnt_q < WD_LIMIT) ? wd_cnt_q + 16'd1 : wd_cnt_q;
        end
        timeout_d = timeout_q | (wd_cnt_d == WD_LIMIT);
    end

    // The drain condition looks at next-cycle pending so a completing divide releases it at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            I_IDLE:  if (hz.int_req_i) state_d = I_WAIT;
            I_WAIT: begin
                if (!hz.int_req_i)                       state_d = I_IDLE;
                else if (!div_pend_d && !hz.bus_hold_i)  state_d = I_FLUSH;
            end
            I_FLUSH: state_d = I_IDLE;
            default: state_d = I_IDLE;
        endcase
    end

    always_comb begin
        div_pend_eff = div_pend_q & ~hz.div_ready_i;
        div_rd_match = (hz.id_rs1_i == div_rd_q) | (hz.id_rs2_i == div_rd_q) |
                       (hz.id_we_i & (hz.id_rd_i == div_rd_q));
        div_hold     = div_pend_eff & (((div_rd_q != 5'd0) & div_rd_match) | hz.id_is_div_i);

        hold_c = 3'd0;
        if (state_q == I_WAIT)                 hold_c = 3'd1;
        if (hz.load_use_i || div_hold)         hold_c = 3'd2;
        if (hz.bus_hold_i)                     hold_c = 3'd4;

        flush_c     = 3'd0;
        jump_c      = 1'b0;
        jump_addr_c = 32'd0;
        if (state_q == I_FLUSH) begin
            flush_c     = 3'd4;
            jump_c      = 1'b1;
            jump_addr_c = hz.int_addr_i;
        end else if (hz.jump_flag_i && (hold_c < 3'd3)) begin
            flush_c     = 3'd3;
            jump_c      = 1'b1;
            jump_addr_c = hz.jump_addr_i;
        end
    end

    assign hz.hold_flag_o     = rst ? hold_c      : 3'd0;
    assign hz.flush_flag_o    = rst ? flush_c     : 3'd0;
    assign hz.jump_flag_o     = rst ? jump_c      : 1'b0;
    assign hz.jump_addr_o     = rst ? jump_addr_c : 32'd0;
    assign hz.int_ack_o       = rst & (state_q == I_FLUSH);
    assign hz.div_pending_o   = rst & div_pend_eff;
    assign hz.stall_timeout_o = rst & timeout_q;
    assign hz.int_state_o     = rst ? state_q : I_IDLE;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one task per scenario, inline checks, one summary line.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.STALL_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hz.jump_flag_i = 1'b0; hz.jump_addr_i = 32'd0; hz.load_use_i = 1'b0;
        hz.id_rs1_i = 5'd0; hz.id_rs2_i = 5'd0; hz.id_rd_i = 5'd0; hz.id_we_i = 1'b0;
        hz.id_is_div_i = 1'b0; hz.div_start_i = 1'b0; hz.div_waddr_i = 5'd0;
        hz.div_ready_i = 1'b0; hz.bus_hold_i = 1'b0; hz.int_req_i = 1'b0; hz.int_addr_i = 32'd0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        hz.bus_hold_i = 1'b1; hz.jump_flag_i = 1'b1; hz.jump_addr_i = 32'h44;
        hz.load_use_i = 1'b1; hz.int_req_i = 1'b1;
        repeat (2) next_cycle();
        #2;
        total++; if (hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL rst_hold got=%0d exp=0", hz.hold_flag_o); end
        total++; if (hz.flush_flag_o !== 3'd0) begin bad++; $display("FAIL rst_flush got=%0d exp=0", hz.flush_flag_o); end
        total++; if (hz.jump_flag_o !== 1'b0 || hz.jump_addr_o !== 32'd0) begin bad++; $display("FAIL rst_jump got=%0b/%0h exp=0/0", hz.jump_flag_o, hz.jump_addr_o); end
        total++; if ({hz.int_ack_o, hz.div_pending_o, hz.stall_timeout_o} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {hz.int_ack_o, hz.div_pending_o, hz.stall_timeout_o}); end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        #2;
        total++; if (hz.int_state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", hz.int_state_o); end
    endtask

    task automatic test_load_use();
        next_cycle();
        hz.load_use_i = 1'b1;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2) begin bad++; $display("FAIL lu_hold got=%0d exp=2", hz.hold_flag_o); end
        total++; if (hz.flush_flag_o !== 3'd0) begin bad++; $display("FAIL lu_flush got=%0d exp=0", hz.flush_flag_o); end
        next_cycle();
        hz.load_use_i = 1'b0;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL lu_release got=%0d exp=0", hz.hold_flag_o); end
    endtask

    task automatic test_div_scoreboard();
        next_cycle();
        hz.div_start_i = 1'b1; hz.div_waddr_i = 5'd5;
        #2;
        total++; if (hz.div_pending_o !== 1'b0 || hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL div_issue got=%0b/%0d exp=0/0", hz.div_pending_o, hz.hold_flag_o); end
        next_cycle();
        hz.div_start_i = 1'b0; hz.id_rs2_i = 5'd5;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2 || hz.div_pending_o !== 1'b1) begin bad++; $display("FAIL div_rs2_hold got=%0d/%0b exp=2/1", hz.hold_flag_o, hz.div_pending_o); end
        next_cycle();
        #2;
        total++; if (hz.hold_flag_o !== 3'd2) begin bad++; $display("FAIL div_rs2_hold2 got=%0d exp=2", hz.hold_flag_o); end
        next_cycle();
        hz.div_ready_i = 1'b1;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0 || hz.div_pending_o !== 1'b0) begin bad++; $display("FAIL div_ready_release got=%0d/%0b exp=0/0", hz.hold_flag_o, hz.div_pending_o); end
        next_cycle();
        hz.div_ready_i = 1'b0;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0 || hz.div_pending_o !== 1'b0) begin bad++; $display("FAIL div_cleared got=%0d/%0b exp=0/0", hz.hold_flag_o, hz.div_pending_o); end
        clear_inputs();
    endtask

    task automatic test_div_corners();
        next_cycle();
        hz.div_start_i = 1'b1; hz.div_waddr_i = 5'd0;
        next_cycle();
        hz.div_start_i = 1'b0; hz.id_rs1_i = 5'd0;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0 || hz.div_pending_o !== 1'b1) begin bad++; $display("FAIL div_x0_nodep got=%0d/%0b exp=0/1", hz.hold_flag_o, hz.div_pending_o); end
        next_cycle();
        hz.id_is_div_i = 1'b1;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2) begin bad++; $display("FAIL div_struct_hold got=%0d exp=2", hz.hold_flag_o); end
        next_cycle();
        hz.div_ready_i = 1'b1; hz.div_start_i = 1'b1; hz.div_waddr_i = 5'd7;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL div_ready_start_hold got=%0d exp=0", hz.hold_flag_o); end
        next_cycle();
        clear_inputs();
        hz.id_rs1_i = 5'd7;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2 || hz.div_pending_o !== 1'b1) begin bad++; $display("FAIL div_start_wins got=%0d/%0b exp=2/1", hz.hold_flag_o, hz.div_pending_o); end
        next_cycle();
        hz.id_rs1_i = 5'd0; hz.id_we_i = 1'b1; hz.id_rd_i = 5'd7;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2) begin bad++; $display("FAIL div_waw_hold got=%0d exp=2", hz.hold_flag_o); end
        next_cycle();
        hz.id_we_i = 1'b0;
        #2;
        total++; if (hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL div_rd_no_we got=%0d exp=0", hz.hold_flag_o); end
        next_cycle();
        hz.div_ready_i = 1'b1;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_jump();
        next_cycle();
        hz.bus_hold_i = 1'b1; hz.jump_flag_i = 1'b1; hz.jump_addr_i = 32'h80;
        #2;
        total++; if (hz.hold_flag_o !== 3'd4 || hz.flush_flag_o !== 3'd0 || hz.jump_flag_o !== 1'b0) begin bad++; $display("FAIL jump_suppress got=%0d/%0d/%0b exp=4/0/0", hz.hold_flag_o, hz.flush_flag_o, hz.jump_flag_o); end
        next_cycle();
        hz.bus_hold_i = 1'b0;
        #2;
        total++; if (hz.flush_flag_o !== 3'd3 || hz.jump_flag_o !== 1'b1 || hz.jump_addr_o !== 32'h80) begin bad++; $display("FAIL jump_taken got=%0d/%0b/%0h exp=3/1/80", hz.flush_flag_o, hz.jump_flag_o, hz.jump_addr_o); end
        next_cycle();
        hz.load_use_i = 1'b1; hz.jump_addr_i = 32'h1234;
        #2;
        total++; if (hz.hold_flag_o !== 3'd2 || hz.flush_flag_o !== 3'd3 || hz.jump_addr_o !== 32'h1234) begin bad++; $display("FAIL jump_over_lu got=%0d/%0d/%0h exp=2/3/1234", hz.hold_flag_o, hz.flush_flag_o, hz.jump_addr_o); end
        next_cycle();
        clear_inputs();
        #2;
        total++; if (hz.jump_flag_o !== 1'b0 || hz.flush_flag_o !== 3'd0) begin bad++; $display("FAIL jump_idle got=%0b/%0d exp=0/0", hz.jump_flag_o, hz.flush_flag_o); end
    endtask

    task automatic test_interrupt();
        next_cycle();
        hz.div_start_i = 1'b1; hz.div_waddr_i = 5'd3;
        next_cycle();
        hz.div_start_i = 1'b0; hz.int_req_i = 1'b1; hz.int_addr_i = 32'h1000;
        #2;
        total++; if (hz.int_state_o !== 2'd0 || hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL int_req_seen got=%0d/%0d exp=0/0", hz.int_state_o, hz.hold_flag_o); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #2;
            total++; if (hz.int_state_o !== 2'd1 || hz.hold_flag_o !== 3'd1 || hz.int_ack_o !== 1'b0) begin bad++; $display("FAIL int_wait got=%0d/%0d/%0b exp=1/1/0", hz.int_state_o, hz.hold_flag_o, hz.int_ack_o); end
        end
        next_cycle();
        hz.div_ready_i = 1'b1;
        #2;
        total++; if (hz.int_ack_o !== 1'b0 || hz.flush_flag_o !== 3'd0) begin bad++; $display("FAIL int_drain got=%0b/%0d exp=0/0", hz.int_ack_o, hz.flush_flag_o); end
        next_cycle();
        hz.div_ready_i = 1'b0; hz.jump_flag_i = 1'b1; hz.jump_addr_i = 32'h80;
        #2;
        total++; if (hz.flush_flag_o !== 3'd4 || hz.jump_flag_o !== 1'b1 || hz.jump_addr_o !== 32'h1000) begin bad++; $display("FAIL int_flush got=%0d/%0b/%0h exp=4/1/1000", hz.flush_flag_o, hz.jump_flag_o, hz.jump_addr_o); end
        total++; if (hz.int_ack_o !== 1'b1) begin bad++; $display("FAIL int_ack got=%0b exp=1", hz.int_ack_o); end
        next_cycle();
        clear_inputs();
        #2;
        total++; if (hz.int_ack_o !== 1'b0 || hz.int_state_o !== 2'd0) begin bad++; $display("FAIL int_ack_pulse got=%0b/%0d exp=0/0", hz.int_ack_o, hz.int_state_o); end
    endtask

    task automatic test_int_drop();
        next_cycle();
        hz.int_req_i = 1'b1; hz.bus_hold_i = 1'b1;
        next_cycle();
        #2;
        total++; if (hz.int_state_o !== 2'd1 || hz.hold_flag_o !== 3'd4) begin bad++; $display("FAIL drop_wait got=%0d/%0d exp=1/4", hz.int_state_o, hz.hold_flag_o); end
        next_cycle();
        hz.int_req_i = 1'b0; hz.bus_hold_i = 1'b0;
        #2;
        total++; if (hz.hold_flag_o !== 3'd1) begin bad++; $display("FAIL drop_hold got=%0d exp=1", hz.hold_flag_o); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #2;
            total++; if (hz.int_state_o !== 2'd0 || hz.int_ack_o !== 1'b0 || hz.flush_flag_o !== 3'd0) begin bad++; $display("FAIL drop_noack got=%0d/%0b/%0d exp=0/0/0", hz.int_state_o, hz.int_ack_o, hz.flush_flag_o); end
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            hz.bus_hold_i = 1'b1;
            #2;
            total++; if (hz.stall_timeout_o !== 1'b0) begin bad++; $display("FAIL wd_early cycle=%0d got=%0b exp=0", i, hz.stall_timeout_o); end
        end
        next_cycle();
        hz.bus_hold_i = 1'b0;
        #2;
        total++; if (hz.stall_timeout_o !== 1'b1) begin bad++; $display("FAIL wd_set got=%0b exp=1", hz.stall_timeout_o); end
        repeat (3) next_cycle();
        #2;
        total++; if (hz.stall_timeout_o !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0b exp=1", hz.stall_timeout_o); end
        next_cycle();
        rst = 1'b0;
        #2;
        total++; if (hz.stall_timeout_o !== 1'b0) begin bad++; $display("FAIL wd_reset got=%0b exp=0", hz.stall_timeout_o); end
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            hz.bus_hold_i = 1'b1;
        end
        next_cycle();
        hz.bus_hold_i = 1'b0;
        #2;
        total++; if (hz.stall_timeout_o !== 1'b0) begin bad++; $display("FAIL wd_three got=%0b exp=0", hz.stall_timeout_o); end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        hz.div_start_i = 1'b1; hz.div_waddr_i = 5'd9;
        next_cycle();
        hz.div_start_i = 1'b0; hz.int_req_i = 1'b1; hz.int_addr_i = 32'h2000;
        next_cycle();
        #2;
        total++; if (hz.int_state_o !== 2'd1 || hz.div_pending_o !== 1'b1) begin bad++; $display("FAIL rmw_pre got=%0d/%0b exp=1/1", hz.int_state_o, hz.div_pending_o); end
        hz.bus_hold_i = 1'b1; hz.jump_flag_i = 1'b1; hz.jump_addr_i = 32'h80;
        rst = 1'b0;
        #1;
        total++; if ({hz.hold_flag_o, hz.flush_flag_o, hz.jump_flag_o, hz.int_ack_o, hz.div_pending_o, hz.int_state_o} !== 12'd0 || hz.jump_addr_o !== 32'd0) begin bad++; $display("FAIL rmw_outs_zero got=%0h/%0h exp=0/0", {hz.hold_flag_o, hz.flush_flag_o, hz.jump_flag_o, hz.int_ack_o, hz.div_pending_o, hz.int_state_o}, hz.jump_addr_o); end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        #2;
        total++; if (hz.int_state_o !== 2'd0 || hz.div_pending_o !== 1'b0 || hz.hold_flag_o !== 3'd0) begin bad++; $display("FAIL rmw_after got=%0d/%0b/%0d exp=0/0/0", hz.int_state_o, hz.div_pending_o, hz.hold_flag_o); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_use();
        test_div_scoreboard();
        test_div_corners();
        test_jump();
        test_interrupt();
        test_int_drop();
        test_watchdog();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end
endmodule
